// File: rtl/ss_scan_driver.sv
// Multiplexed common-anode seven-segment scanner: hex decode, PWM dimming, blink,
// leading-zero blanking, and a per-slot ghosting guard; display data is swapped in on frame boundaries.
module ss_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_CYCLES = 20000,
  parameter int GUARD          = 16,
  parameter int BRIGHT_W       = 4,
  parameter int BLINK_FRAMES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   mask,
  input  logic [NUM_DIGITS-1:0]   blink,
  input  logic                    lzb_en,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);
  localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int FR_W  = $clog2(BLINK_FRAMES);

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] data;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   mask;
    logic [NUM_DIGITS-1:0]   blink;
  } buf_t;

  logic [CNT_W-1:0]      cnt;
  logic [SEL_W-1:0]      idx;
  logic [FR_W-1:0]       fcnt;
  buf_t                  pend, act;
  logic                  pvld;
  logic                  slot_end, frame_end, guard_ok, pwm_on, blink_dark, lit;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] lz_blank, an_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end  = (cnt == CNT_W'(REFRESH_CYCLES - 1));
  assign frame_end = slot_end && (idx == SEL_W'(NUM_DIGITS - 1));

  generate
    if (GUARD == 0) begin : g_noguard
      assign guard_ok = 1'b1;
    end else begin : g_guard
      assign guard_ok = (32'(cnt) >= 32'(GUARD));
    end
  endgenerate

  assign pwm_on     = (&brightness) || (cnt[BRIGHT_W-1:0] < brightness);
  assign blink_dark = act.blink[idx] && (fcnt >= FR_W'(BLINK_FRAMES / 2));
  assign nib        = act.data[4*idx +: 4];

  // Walk down from the top digit; masked digits neither blank nor stop the run of zeros.
  always_comb begin : lzb_calc
    logic seen;
    seen     = 1'b0;
    lz_blank = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (act.mask[i]) begin
        if (act.data[4*i +: 4] != 4'h0) seen = 1'b1;
        else if (!seen)                 lz_blank[i] = lzb_en;
      end
    end
  end

  assign lit = act.mask[idx] && guard_ok && pwm_on && !blink_dark && !lz_blank[idx];

  always_comb begin
    an_nxt = '1;
    if (lit) an_nxt[idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      fcnt        <= '0;
      pend        <= '0;
      act         <= '0;
      pvld        <= 1'b0;
      seg         <= 7'h7F;
      dp_n        <= 1'b1;
      an          <= '1;
      frame_start <= 1'b0;
    end else begin
      cnt         <= slot_end ? '0 : cnt + 1'b1;
      frame_start <= frame_end;
      if (slot_end) idx <= (idx == SEL_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (frame_end) begin
        fcnt <= (fcnt == FR_W'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
        if (pvld) act <= pend;
      end
      // A load on the boundary cycle must survive into the next frame.
      if (load) begin
        pend <= '{data: data, dp: dp_in, mask: mask, blink: blink};
        pvld <= 1'b1;
      end else if (frame_end) begin
        pvld <= 1'b0;
      end
      seg  <= lit ? hex7(nib) : 7'h7F;
      dp_n <= lit ? ~act.dp[idx] : 1'b1;
      an   <= an_nxt;
    end
  end
endmodule

// File: tb/tb_ss_scan_driver.sv
// Scoreboard bench for ss_scan_driver: expected outputs per counter state are queued before each edge.
module tb_ss_scan_driver;
  localparam int N = 4, RC = 20, GD = 2, BW = 2, BF = 4, FRM = RC * N;

  logic        clk = 1'b0, rst;
  logic [15:0] data;
  logic [3:0]  dp_in, mask, blink;
  logic        lzb_en, load;
  logic [1:0]  brightness;
  logic [6:0]  seg;
  logic        dp_n, frame_start;
  logic [3:0]  an;

  ss_scan_driver #(.NUM_DIGITS(N), .REFRESH_CYCLES(RC), .GUARD(GD), .BRIGHT_W(BW), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .data(data), .dp_in(dp_in), .mask(mask), .blink(blink),
    .lzb_en(lzb_en), .load(load), .brightness(brightness),
    .seg(seg), .dp_n(dp_n), .an(an), .frame_start(frame_start));

  always #5 clk = ~clk;

  typedef struct { logic [6:0] seg; logic dp_n; logic [3:0] an; logic fs; } exp_t;
  exp_t sb[$];

  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int passed = 0, total = 0;
  int t;
  logic [15:0] a_data, p_data;
  logic [3:0]  a_dp, a_mask, a_blink, p_dp, p_mask, p_blink;
  bit          pvld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin passed++; end
    else $error("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, expv);
  endtask

  task automatic model_clear();
    t = 0; pvld = 0;
    a_data = '0; a_dp = '0; a_mask = '0; a_blink = '0;
    p_data = '0; p_dp = '0; p_mask = '0; p_blink = '0;
  endtask

  // One clock: queue expectation for the current counter state, clock, then compare.
  task automatic cyc(input bit ld);
    exp_t e;
    int cnt, idx, fr;
    bit lit, seen, lzb;
    logic [3:0] nib;
    cnt = t % RC; idx = (t / RC) % N; fr = (t / FRM) % BF;
    nib = a_data[idx*4 +: 4];
    lzb = 0;
    if (lzb_en && idx != 0) begin
      seen = 0;
      for (int i = N - 1; i > idx; i--)
        if (a_mask[i] && a_data[i*4 +: 4] != 4'h0) seen = 1;
      lzb = !seen && (nib == 4'h0);
    end
    lit = a_mask[idx] && cnt >= GD && (brightness == 2'd3 || (cnt % 4) < brightness)
          && !(a_blink[idx] && fr >= BF / 2) && !lzb;
    e.seg  = lit ? dec_tab[nib] : 7'h7F;
    e.dp_n = lit ? ~a_dp[idx] : 1'b1;
    e.an   = lit ? ~(4'b0001 << idx) : 4'hF;
    e.fs   = ((t + 1) % FRM == 0);
    sb.push_back(e);
    load = ld;
    if (t % FRM == FRM - 1 && pvld) begin
      a_data = p_data; a_dp = p_dp; a_mask = p_mask; a_blink = p_blink; pvld = 0;
    end
    if (ld) begin
      p_data = data; p_dp = dp_in; p_mask = mask; p_blink = blink; pvld = 1;
    end
    t++;
    @(posedge clk); #1;
    load = 1'b0;
    e = sb.pop_front();
    chk("seg", 32'(seg), 32'(e.seg));
    chk("dp_n", 32'(dp_n), 32'(e.dp_n));
    chk("an", 32'(an), 32'(e.an));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_seg"}, 32'(seg), 32'h7F);
    chk({tag, "_dp_n"}, 32'(dp_n), 32'h1);
    chk({tag, "_an"}, 32'(an), 32'hF);
    chk({tag, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  initial begin
    rst = 1'b1; data = '0; dp_in = '0; mask = '0; blink = '0;
    lzb_en = 1'b0; load = 1'b0; brightness = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    model_clear();
    rst = 1'b0;

    // Basic scan: load during frame 0, visible from frame 1.
    data = 16'h8421; mask = 4'hF; dp_in = 4'b0100; brightness = 2'd3;
    cyc(1'b1); run(79);
    run(40);
    // Double buffer: load at idx 2, digits 2 and 3 keep old values this frame.
    data = 16'h1111; cyc(1'b1); run(39);
    // Two loads in one frame: only the last is applied.
    data = 16'h2222; cyc(1'b1); run(10);
    data = 16'h3333; cyc(1'b1); run(68);
    // Brightness 1 then 0.
    brightness = 2'd1; run(80);
    brightness = 2'd0; run(80);
    // Blink on digit 0 across a full blink period.
    brightness = 2'd3; data = 16'h8421; blink = 4'b0001;
    cyc(1'b1); run(79);
    run(320);
    // Leading-zero blanking.
    blink = 4'b0000; lzb_en = 1'b1; data = 16'h0050;
    cyc(1'b1); run(79);
    data = 16'h0000; cyc(1'b1); run(79);
    run(80);
    // Reset mid-slot at idx 2, cnt 7.
    run(47);
    rst = 1'b1;
    #1;
    chk_reset("midrst");
    rst = 1'b0;
    model_clear();
    lzb_en = 1'b0; data = 16'h8421; mask = 4'hF; dp_in = 4'b0001; blink = 4'b0000;
    cyc(1'b1); run(79);
    run(80);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for N common-anode digits with hex decode, per-digit enable, blink and decimal point, global PWM brightness, optional leading-zero blanking and a ghosting guard. Display data is double-buffered: values are latched on a load strobe and applied only at a frame boundary, so a refresh never shows a mix of old and new digits. Sits between the status/register logic and the board's segment/anode pins. Replaces the fixed 8-digit scanner.

Parameters:
NUM_DIGITS, 8, number of digits scanned (2..16); SEL_W = max(1, clog2(NUM_DIGITS)) derived locally.
REFRESH_CYCLES, 20000, clk cycles per digit slot (>= 2^BRIGHT_W + GUARD).
GUARD, 16, cycles at start of each slot with all anodes off (0 = no guard).
BRIGHT_W, 4, brightness control width.
BLINK_FRAMES, 32, full blink period in frames (even, >= 2).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
data  in  4*NUM_DIGITS  hex nibbles, digit i = data[4i+3:4i]
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
mask  in  NUM_DIGITS  digit enable, 1 = shown
blink  in  NUM_DIGITS  1 = digit blinks
lzb_en  in  1  leading-zero blanking enable
load  in  1  one-cycle strobe: capture data/dp_in/mask/blink into pending buffer
brightness  in  BRIGHT_W  global duty; all-ones = full on, 0 = off
seg  out  7  segments a..g on seg[0]..seg[6], active-low, registered
dp_n  out  1  decimal point, active-low, registered
an  out  NUM_DIGITS  anodes, active-low, registered
frame_start  out  1  one-cycle pulse when scan index wraps to digit 0

Behaviour:
- Reset (async, rst=1): seg=7'h7F, dp_n=1, an=all ones, frame_start=0; slot counter, digit index, PWM counter, frame counter, pending and active buffers = 0; pending-valid flag = 0.
- Slot counter cnt counts 0..REFRESH_CYCLES-1, wraps to 0; on wrap idx advances; idx NUM_DIGITS-1 -> 0 (non-power-of-2 counts wrap correctly, no dead slots).
- frame_start asserted in the first cycle in which idx=0 and cnt=0 after a wrap (not after reset).
- load=1: pending buffer <= inputs, pending-valid <= 1. Last load before the boundary wins.
- Frame boundary (idx wrap to 0): if pending-valid, active <= pending, pending-valid <= 0. A load in the boundary cycle itself lands in pending and applies at the next boundary.
- PWM: pwm = cnt modulo 2^BRIGHT_W. Digit lit when brightness==all-ones, or pwm < brightness.
- Blink: frame counter 0..BLINK_FRAMES-1, increments per frame. Blinking digits are dark while frame counter >= BLINK_FRAMES/2.
- Leading-zero blanking (lzb_en=1): from the top digit down, enabled digits with nibble 0 are blanked until the first nonzero enabled digit. Digit 0 is never blanked. Masked digits are skipped, not counted as nonzero.
- Anode for idx is driven low iff mask[idx] & cnt>=GUARD & PWM on & not blink-dark & not LZ-blanked; all other anodes high.
- Blanked digit: seg=7'h7F, dp_n=1.
- Decode table (standard hex, active-low {g..a}): 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10,A=08,b=03,C=46,d=21,E=06,F=0E.
- Latency: outputs registered, one clk behind the counter state they reflect.
- rst mid-frame: everything returns to reset values immediately; pending load is discarded.

Test Plan:
- Bench params NUM_DIGITS=4, REFRESH_CYCLES=20, GUARD=2, BRIGHT_W=2, BLINK_FRAMES=4.
- Scan: load data=16'h8421, mask=4'hF, brightness=3 -> after boundary, an cycles E,D,B,7 with seg 79,24,19,00. an=F during the first 2 cycles of each slot. frame_start pulses every 80 cycles.
- Double buffer: load 16'h1111 mid-frame at idx=2 -> idx 2,3 still show old values; new values appear from the next idx=0. Two loads in one frame -> only the last one is applied.
- Brightness: brightness=1 -> anode low only on cycles where pwm=0 within the non-guard part of the slot. brightness=0 -> an stays F.
- Blink/LZB: blink=4'b0001 -> digit 0 dark in frames 2,3 and lit in frames 0,1. lzb_en=1, data=16'h0050 -> digits 3 and 2 blank, digit 1 shows 12, digit 0 shows 40. data=0 -> only digit 0 shows 40.
- Reset mid-slot: rst pulse at idx=2, cnt=7 -> same cycle seg=7F, an=F, dp_n=1. After release, scan restarts at idx 0 with zeroed buffers.
